// File: rtl/ibuf_hstl_rx_filter.sv
// ibuf_hstl_rx_filter: per-bit pad synchronizer and glitch filter for HSTL receive lines.
// Each bit is synchronized into the C domain, must differ from the current level for
// FILTER consecutive enabled cycles before O follows, and emits one-cycle RISE/FALL strobes.
module ibuf_hstl_rx_filter #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,  // legal 2..4
  parameter int unsigned FILTER      = 3   // legal 1..15
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] I,
  input  logic             EN,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             STABLE
);

  localparam int unsigned     CntW   = $clog2(FILTER) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  logic [CntW-1:0]  cnt_q  [WIDTH];
  logic [CntW-1:0]  cnt_d  [WIDTH];
  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] bit_stable;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; keeps sampling even while the filter is disabled.
  always_ff @(posedge C) begin
    if (R) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= I;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-bit filter next state: count disagreeing samples, commit on the FILTER-th one.
  always_comb begin
    o_d    = o_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned n = 0; n < WIDTH; n++) begin
      cnt_d[n] = '0;
      if (EN && (sync_out[n] != o_q[n])) begin
        if (cnt_q[n] == CntMax) begin
          o_d[n]    = sync_out[n];
          rise_d[n] = sync_out[n];
          fall_d[n] = ~sync_out[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
  end

  // Filter state and registered outputs.
  always_ff @(posedge C) begin
    if (R) begin
      o_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      o_q    <= o_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int unsigned n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  // A bit is settled when nothing is pending and the synchronized value matches O.
  always_comb begin
    bit_stable = '0;
    for (int unsigned n = 0; n < WIDTH; n++) begin
      bit_stable[n] = (cnt_q[n] == '0) && (sync_out[n] == o_q[n]);
    end
  end

  assign O      = o_q;
  assign RISE   = rise_q;
  assign FALL   = fall_q;
  assign STABLE = &bit_stable;

endmodule

// File: tb/tb_ibuf_hstl_rx_filter.sv
// Bench for ibuf_hstl_rx_filter: two builds share one stimulus stream; a run-length model
// predicts each edge's outputs into per-build queues that a monitor drains and compares.
module tb_ibuf_hstl_rx_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic [1:0] pad;

  logic [1:0] o_a, rise_a, fall_a;
  logic       stable_a;
  logic [1:0] o_b, rise_b, fall_b;
  logic       stable_b;

  ibuf_hstl_rx_filter #(.WIDTH(2), .SYNC_STAGES(2), .FILTER(3)) dut_a (
    .C(clk), .R(rst), .I(pad), .EN(en),
    .O(o_a), .RISE(rise_a), .FALL(fall_a), .STABLE(stable_a)
  );

  ibuf_hstl_rx_filter #(.WIDTH(2), .SYNC_STAGES(3), .FILTER(1)) dut_b (
    .C(clk), .R(rst), .I(pad), .EN(en),
    .O(o_b), .RISE(rise_b), .FALL(fall_b), .STABLE(stable_b)
  );

  typedef struct packed {
    logic [1:0] o;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       stable;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int errors = 0;
  int checks = 0;
  int mon_edge = 0;

  // Reference model: sync output is simply the pad value sampled a fixed number of edges
  // earlier (zero if that sample predates the most recent reset); O follows once the
  // disagreement has lasted FILTER consecutive enabled edges.
  localparam int NSAMP = 8192;
  logic [1:0] samp [NSAMP];
  int edge_n   = 0;
  int last_rst = -1000;
  int dly  [2] = '{2, 3};
  int filt [2] = '{3, 1};
  logic [1:0] m_o   [2];
  int         m_run [2][2];

  function automatic logic [1:0] seen_at(input int m, input int n);
    int idx;
    idx = n - dly[m];
    if (idx >= 0 && idx > last_rst) return samp[idx];
    return 2'b00;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [1:0] i);
    exp_t       x;
    logic [1:0] seen;
    logic [1:0] after;
    samp[edge_n] = i;
    if (r) last_rst = edge_n;
    for (int m = 0; m < 2; m++) begin
      x = '0;
      if (r) begin
        m_o[m] = 2'b00;
        m_run[m][0] = 0;
        m_run[m][1] = 0;
      end else begin
        seen = seen_at(m, edge_n);
        for (int b = 0; b < 2; b++) begin
          if (!e || seen[b] == m_o[m][b]) begin
            m_run[m][b] = 0;
          end else begin
            m_run[m][b] = m_run[m][b] + 1;
            if (m_run[m][b] == filt[m]) begin
              m_o[m][b]  = seen[b];
              x.rise[b]  = seen[b];
              x.fall[b]  = ~seen[b];
              m_run[m][b] = 0;
            end
          end
        end
      end
      after = seen_at(m, edge_n + 1);
      x.stable = (m_run[m][0] == 0) && (m_run[m][1] == 0) && (after == m_o[m]);
      x.o = m_o[m];
      if (m == 0) q_a.push_back(x);
      else        q_b.push_back(x);
    end
    edge_n++;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] i);
    @(negedge clk);
    rst = r;
    en  = e;
    pad = i;
    model_edge(r, e, i);
  endtask

  task automatic drive_n(input int n, input logic r, input logic e, input logic [1:0] i);
    for (int k = 0; k < n; k++) drive(r, e, i);
  endtask

  task automatic check(input string name, input exp_t act, input exp_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s edge %0d: got o=%b rise=%b fall=%b stable=%b, want o=%b rise=%b fall=%b stable=%b",
               name, mon_edge, act.o, act.rise, act.fall, act.stable,
               want.o, want.rise, want.fall, want.stable);
    end
  endtask

  task automatic check_excl(input string name, input logic [1:0] r, input logic [1:0] f);
    checks++;
    if ((r & f) != 2'b00) begin
      errors++;
      $display("FAIL %s edge %0d: rise=%b fall=%b overlap, want none", name, mon_edge, r, f);
    end
  endtask

  // Monitor: one expected record per edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t ea;
    exp_t eb;
    #1;
    if (q_a.size() != 0 && q_b.size() != 0) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      check("dut_a", {o_a, rise_a, fall_a, stable_a}, ea);
      check("dut_b", {o_b, rise_b, fall_b, stable_b}, eb);
      check_excl("dut_a_strobes", rise_a, fall_a);
      check_excl("dut_b_strobes", rise_b, fall_b);
      mon_edge++;
    end
  end

  initial begin
    logic [1:0] p;
    logic       r;
    logic       e;
    rst = 1'b1;
    en  = 1'b1;
    pad = 2'b11;

    // Reset with both pads high, then release: O qualifies after the full latency.
    drive_n(2, 1'b1, 1'b1, 2'b11);
    drive_n(8, 1'b0, 1'b1, 2'b11);
    drive_n(8, 1'b0, 1'b1, 2'b00);

    // Single-bit step up and back down.
    drive_n(8, 1'b0, 1'b1, 2'b01);
    drive_n(8, 1'b0, 1'b1, 2'b00);

    // Glitch rejection: 2-cycle pulse rejected, 3-cycle pulse passes.
    drive_n(2, 1'b0, 1'b1, 2'b01);
    drive_n(8, 1'b0, 1'b1, 2'b00);
    drive_n(3, 1'b0, 1'b1, 2'b01);
    drive_n(10, 1'b0, 1'b1, 2'b00);

    // Low-going pulses from a high level.
    drive_n(8, 1'b0, 1'b1, 2'b11);
    drive_n(2, 1'b0, 1'b1, 2'b10);
    drive_n(6, 1'b0, 1'b1, 2'b11);
    drive_n(3, 1'b0, 1'b1, 2'b10);
    drive_n(8, 1'b0, 1'b1, 2'b11);
    drive_n(8, 1'b0, 1'b1, 2'b00);

    // Enable gating: change held while disabled, then released.
    drive_n(10, 1'b0, 1'b0, 2'b10);
    drive_n(6, 1'b0, 1'b1, 2'b10);
    drive_n(8, 1'b0, 1'b1, 2'b00);

    // Reset mid-count discards the pending transition.
    drive_n(3, 1'b0, 1'b1, 2'b01);
    drive(1'b1, 1'b1, 2'b01);
    drive_n(8, 1'b0, 1'b1, 2'b01);
    drive_n(8, 1'b0, 1'b1, 2'b00);

    // Simultaneous steps on both bits.
    drive_n(8, 1'b0, 1'b1, 2'b11);
    drive_n(8, 1'b0, 1'b1, 2'b00);

    // Randomized traffic: frequent toggles give pulses of many lengths.
    p = 2'b00;
    for (int k = 0; k < 2000; k++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 3) == 0) p[b] = ~p[b];
      end
      drive(r, e, p);
    end
    drive_n(10, 1'b0, 1'b1, p);

    @(posedge clk);
    #2;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
